// File: rtl/anchor_gen_3d_pkg.sv
// Shared types and widths for the 3-D anchor generator.
// Holds the FSM state encoding, the latched run configuration and its legality check.
package anchor_gen_3d_pkg;

   localparam int unsigned CNT_W = 16;
   localparam int unsigned CH_W  = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic             rpt;
      logic [CNT_W-1:0] width;
      logic [CNT_W-1:0] height;
      logic [CH_W-1:0]  chan;
      logic [CNT_W-1:0] w_step;
      logic [CNT_W-1:0] h_step;
   } cfg_t;

   // A run needs every extent and every stride non-zero.
   function automatic logic cfg_legal(input cfg_t cfg);
      return (cfg.width  != '0) && (cfg.height != '0) && (cfg.chan != '0) &&
             (cfg.w_step != '0) && (cfg.h_step != '0);
   endfunction

endpackage

// File: rtl/anchor_gen_3d_axis_cnt.sv
// One axis of the anchor walk: steps a coordinate by a stride and wraps at the extent.
// The sum is formed one bit wider so a stride larger than the extent never overflows.
module anchor_gen_3d_axis_cnt #(
   parameter int unsigned W = 16
) (
   input  logic [W-1:0] value,
   input  logic [W-1:0] step,
   input  logic [W-1:0] extent,
   input  logic         inc_en,
   output logic [W-1:0] next_c,
   output logic         wrap_c,
   output logic         at_last_c
);

   logic [W:0] sum;
   logic       fits;

   always_comb begin
      sum       = {1'b0, value} + {1'b0, step};
      fits      = sum < {1'b0, extent};
      at_last_c = !fits;
      wrap_c    = inc_en & !fits;
      next_c    = value;
      if (inc_en) begin
         next_c = fits ? sum[W-1:0] : '0;
      end
   end

endmodule

// File: rtl/anchor_gen_3d.sv
// Walks (channel, row, col) anchors over a C x H x W map, col innermost, with a
// valid/ready output, one-shot or repeat runs, abort, done and config-error pulses.
module anchor_gen_3d
   import anchor_gen_3d_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             cfg_repeat,
   input  logic [CNT_W-1:0] cfg_width,
   input  logic [CNT_W-1:0] cfg_height,
   input  logic [CH_W-1:0]  cfg_chan,
   input  logic [CNT_W-1:0] cfg_w_step,
   input  logic [CNT_W-1:0] cfg_h_step,
   output logic             anchor_valid,
   input  logic             anchor_ready,
   output logic [CH_W-1:0]  anchor_c,
   output logic [CNT_W-1:0] anchor_h,
   output logic [CNT_W-1:0] anchor_w,
   output logic             anchor_last,
   output logic             busy,
   output logic             done,
   output logic             cfg_err
);

   state_t           state;
   cfg_t             cfg_in;
   cfg_t             cfg_q;
   logic             accept;
   logic [CNT_W-1:0] w_next;
   logic [CNT_W-1:0] h_next;
   logic [CH_W-1:0]  c_next;
   logic             w_wrap;
   logic             h_wrap;
   logic             c_wrap;
   logic             w_last;
   logic             h_last;
   logic             c_last;

   assign cfg_in = '{rpt:    cfg_repeat,
                     width:  cfg_width,
                     height: cfg_height,
                     chan:   cfg_chan,
                     w_step: cfg_w_step,
                     h_step: cfg_h_step};

   assign accept = anchor_valid & anchor_ready;

   // Carry chain: col wrap advances row, row wrap advances channel.
   anchor_gen_3d_axis_cnt #(.W(CNT_W)) u_col (
      .value     (anchor_w),
      .step      (cfg_q.w_step),
      .extent    (cfg_q.width),
      .inc_en    (accept),
      .next_c    (w_next),
      .wrap_c    (w_wrap),
      .at_last_c (w_last)
   );

   anchor_gen_3d_axis_cnt #(.W(CNT_W)) u_row (
      .value     (anchor_h),
      .step      (cfg_q.h_step),
      .extent    (cfg_q.height),
      .inc_en    (w_wrap),
      .next_c    (h_next),
      .wrap_c    (h_wrap),
      .at_last_c (h_last)
   );

   anchor_gen_3d_axis_cnt #(.W(CH_W)) u_chan (
      .value     (anchor_c),
      .step      (CH_W'(1)),
      .extent    (cfg_q.chan),
      .inc_en    (h_wrap),
      .next_c    (c_next),
      .wrap_c    (c_wrap),
      .at_last_c (c_last)
   );

   assign anchor_last = anchor_valid & w_last & h_last & c_last;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         cfg_q        <= '0;
         anchor_c     <= '0;
         anchor_h     <= '0;
         anchor_w     <= '0;
         anchor_valid <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         cfg_err      <= 1'b0;
      end else begin
         done    <= 1'b0;
         cfg_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               // abort outranks a coincident start
               if (start && !abort) begin
                  if (cfg_legal(cfg_in)) begin
                     cfg_q        <= cfg_in;
                     anchor_c     <= '0;
                     anchor_h     <= '0;
                     anchor_w     <= '0;
                     anchor_valid <= 1'b1;
                     busy         <= 1'b1;
                     state        <= ST_RUN;
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (abort) begin
                  anchor_c     <= '0;
                  anchor_h     <= '0;
                  anchor_w     <= '0;
                  anchor_valid <= 1'b0;
                  busy         <= 1'b0;
                  state        <= ST_IDLE;
               end else if (accept) begin
                  // after the final anchor the carry chain already yields (0,0,0)
                  anchor_c <= c_next;
                  anchor_h <= h_next;
                  anchor_w <= w_next;
                  if (c_wrap && !cfg_q.rpt) begin
                     anchor_valid <= 1'b0;
                     busy         <= 1'b0;
                     done         <= 1'b1;
                     state        <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
